mul_share_sched: RTL and testbench
==================================

// Module: mul_share_sched
// PURPOSE
//   Time-shares one combinational WIDTHxWIDTH multiplier (the mul core, 2*WIDTH product) between two requesters.
//   Round-robin arbitration, valid/ready request and response channels per requester.
//   Registers operands, waits SETTLE cycles as a multicycle path, then captures and returns the product.
//   Sits between the user logic and the mul instance; the mul core itself is instantiated outside.
// PARAMETERS
//   WIDTH   16  operand width; product is 2*WIDTH
//   SETTLE  2   cycles mul_c is given to settle after operands change; legal range 1..15
// PORTS
//   clk          in   1        clock; all state on posedge
//   rst          in   1        asynchronous, active-high reset
//   req0_valid   in   1        requester 0 has operands
//   req0_ready   out  1        requester 0 operands accepted this cycle
//   req0_a       in   WIDTH    requester 0 multiplicand
//   req0_b       in   WIDTH    requester 0 multiplier
//   rsp0_valid   out  1        requester 0 result valid
//   rsp0_ready   in   1        requester 0 takes result
//   rsp0_c       out  2*WIDTH  requester 0 result
//   req1_*/rsp1_*   same set as requester 0, for requester 1
//   mul_a        out  WIDTH    operand A to the shared multiplier (registered)
//   mul_b        out  WIDTH    operand B to the shared multiplier (registered)
//   mul_c        in   2*WIDTH  product from the shared multiplier
//   busy         out  1        high in any state other than IDLE
// BEHAVIOUR
//   Reset: state=IDLE; op_a, op_b, result, cnt=0; last=1 (requester 0 wins the first tie). All outputs 0.
//   FSM: IDLE -> WAIT -> RESP -> IDLE.
//   IDLE:
//     - Grant g = the only valid requester, or on a tie the requester != last.
//     - reqg_ready=1 combinationally in the same cycle; nothing else asserts a ready.
//     - On that edge: op_a/op_b <= reqg_a/b; gid <= g; cnt <= SETTLE-1; -> WAIT.
//   WAIT:
//     - mul_a/mul_b = op_a/op_b (held stable).
//     - cnt decrements; at cnt==0, result <= mul_c (or MAC value, see below) and -> RESP.
//   RESP:
//     - rsp{gid}_valid=1 and rsp{gid}_c=result, both stable until rsp{gid}_ready.
//     - On handshake: last <= gid; -> IDLE.
//     - The other rsp_valid is 0; no new request is accepted.
//   Latency: accept edge t -> rsp_valid from cycle t+SETTLE+1. Throughput: one op per SETTLE+2 cycles minimum.
//   rsp_c: both ports are driven with result; only the valid one is meaningful.
//   Width rule: product is the full unsigned 2*WIDTH result; no truncation.
//   Boundary cases:
//     - req valid dropped before ready: no effect.
//     - Both valid continuously: strict alternation 0,1,0,1...
//     - rsp_ready held low: FSM stalls in RESP indefinitely; requests stay unacked.
//     - rst mid-op: abort immediately; the pending result is lost; no rsp_valid after reset.
// CONFIGURATION
//   MUL_SCHED_MAC_EN defined:
//     - Adds acc0/acc1 (2*WIDTH, reset 0) and inputs req0_clr/req1_clr (1 bit, sampled at accept).
//     - WAIT capture: result <= (clr ? 0 : acc{gid}) + mul_c, modulo 2^(2*WIDTH).
//     - RESP handshake: acc{gid} <= result.
//   MUL_SCHED_MAC_EN undefined: no accumulators, no clr ports; result = mul_c.
// TESTING
//   T1 reset: rst=1 mid-WAIT -> all outputs 0, state IDLE, busy=0; no rsp_valid afterwards.
//   T2 single op: req0 a=3, b=5, rsp0_ready=1 -> req0_ready for 1 cycle; rsp0_valid at t+3 (SETTLE=2); rsp0_c=15.
//   T3 tie: both valid, 0: 0xFFFF*0xFFFF, 1: 2*7 -> order 0,1,0,1; rsp0_c=0xFFFE0001, rsp1_c=14.
//   T4 backpressure: rsp1_ready=0 for 10 cycles -> rsp1_valid/rsp1_c stable; req0_ready stays 0 throughout.
//   T5 MAC (macro on): req0 2*3, then 4*5, then clr=1 with 1*1 -> rsp0_c = 6, 26, 1.
//   T6 random: 1000 mixed ops, random ready stalls -> every result matches a*b; no grant starvation >1 op.

Source files
------------

// File: rtl/mul_share_sched_if.sv
// Handshake bundle between two requesters, the scheduler and the shared multiplier.
// MUL_SCHED_MAC_EN adds the per-requester accumulator clear inputs.
`timescale 1ns/1ps
interface mul_share_sched_if #(
    parameter int WIDTH = 16
);
    logic               req0_valid;
    logic               req0_ready;
    logic [WIDTH-1:0]   req0_a;
    logic [WIDTH-1:0]   req0_b;
    logic               rsp0_valid;
    logic               rsp0_ready;
    logic [2*WIDTH-1:0] rsp0_c;

    logic               req1_valid;
    logic               req1_ready;
    logic [WIDTH-1:0]   req1_a;
    logic [WIDTH-1:0]   req1_b;
    logic               rsp1_valid;
    logic               rsp1_ready;
    logic [2*WIDTH-1:0] rsp1_c;

    logic [WIDTH-1:0]   mul_a;
    logic [WIDTH-1:0]   mul_b;
    logic [2*WIDTH-1:0] mul_c;
    logic               busy;
`ifdef MUL_SCHED_MAC_EN
    logic               req0_clr;
    logic               req1_clr;
`endif

    modport master (
`ifdef MUL_SCHED_MAC_EN
        output req0_clr, req1_clr,
`endif
        output req0_valid, req0_a, req0_b, rsp0_ready,
        output req1_valid, req1_a, req1_b, rsp1_ready,
        output mul_c,
        input  req0_ready, rsp0_valid, rsp0_c,
        input  req1_ready, rsp1_valid, rsp1_c,
        input  mul_a, mul_b, busy
    );

    modport slave (
`ifdef MUL_SCHED_MAC_EN
        input  req0_clr, req1_clr,
`endif
        input  req0_valid, req0_a, req0_b, rsp0_ready,
        input  req1_valid, req1_a, req1_b, rsp1_ready,
        input  mul_c,
        output req0_ready, rsp0_valid, rsp0_c,
        output req1_ready, rsp1_valid, rsp1_c,
        output mul_a, mul_b, busy
    );
endinterface

// File: rtl/mul_share_sched.sv
// Round-robin time-sharing of one external multiplier between two requesters.
// Optional MUL_SCHED_MAC_EN turns each requester's channel into a multiply-accumulate.
`timescale 1ns/1ps
module mul_share_sched #(
    parameter int WIDTH  = 16,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    mul_share_sched_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [2*WIDTH-1:0] result;
    logic [2*WIDTH-1:0] cap;
    logic [3:0]         cnt;
    logic               gid;
    logic               last;
    logic               grant;
    logic               accept;
    logic               rsp_done;
    logic               settled;

`ifdef MUL_SCHED_MAC_EN
    logic               clr_q;
    logic [2*WIDTH-1:0] acc0;
    logic [2*WIDTH-1:0] acc1;
`endif

    // Tie goes to whoever was not served last; reset gates ready low.
    assign grant    = bus.req1_valid & (~bus.req0_valid | ~last);
    assign accept   = (state == IDLE) & ~rst
                    & (bus.req0_valid | bus.req1_valid);
    assign settled  = (state == WAIT) & (cnt == 4'd0);
    assign rsp_done = (state == RESP)
                    & (gid ? bus.rsp1_ready : bus.rsp0_ready);

    always_comb begin
        cap = bus.mul_c;
`ifdef MUL_SCHED_MAC_EN
        if (!clr_q)
            cap = (gid ? acc1 : acc0) + bus.mul_c;
`endif
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept)   state_nx = WAIT;
            WAIT:    if (settled)  state_nx = RESP;
            RESP:    if (rsp_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a   <= '0;
            op_b   <= '0;
            result <= '0;
            cnt    <= '0;
            gid    <= 1'b0;
            last   <= 1'b1;
        end else begin
            if (accept) begin
                op_a <= grant ? bus.req1_a : bus.req0_a;
                op_b <= grant ? bus.req1_b : bus.req0_b;
                gid  <= grant;
                cnt  <= 4'(SETTLE - 1);
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (settled)
                result <= cap;
            if (rsp_done)
                last <= gid;
        end
    end

`ifdef MUL_SCHED_MAC_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_q <= 1'b0;
            acc0  <= '0;
            acc1  <= '0;
        end else begin
            if (accept)
                clr_q <= grant ? bus.req1_clr : bus.req0_clr;
            if (rsp_done && !gid)
                acc0 <= result;
            if (rsp_done && gid)
                acc1 <= result;
        end
    end
`endif

    assign bus.req0_ready = accept & ~grant;
    assign bus.req1_ready = accept & grant;
    assign bus.rsp0_valid = (state == RESP) & ~gid;
    assign bus.rsp1_valid = (state == RESP) & gid;
    assign bus.rsp0_c     = result;
    assign bus.rsp1_c     = result;
    assign bus.mul_a      = op_a;
    assign bus.mul_b      = op_b;
    assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_mul_share_sched.sv
// Self-checking bench for mul_share_sched: directed vectors, corner sequences
// and a randomized run against a queue-free transaction-level reference model.
`timescale 1ns/1ps
module tb_mul_share_sched;
    localparam int W      = 16;
    localparam int SETTLE = 2;
    localparam int LAT    = SETTLE + 1;

    typedef logic [2*W-1:0] prod_t;

    typedef struct {
        int          w;
        logic [W-1:0] a;
        logic [W-1:0] b;
        prod_t        c;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc_n  = 0;

    mul_share_sched_if #(.WIDTH(W)) bus();

    mul_share_sched #(.WIDTH(W), .SETTLE(SETTLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // The shared multiplier lives outside the scheduler.
    assign bus.mul_c = prod_t'(bus.mul_a) * prod_t'(bus.mul_b);

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc_n);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        cyc_n++;
    endtask

    function automatic logic rdy(input int w);
        return (w != 0) ? bus.req1_ready : bus.req0_ready;
    endfunction

    function automatic logic rv(input int w);
        return (w != 0) ? bus.rsp1_valid : bus.rsp0_valid;
    endfunction

    function automatic prod_t rc(input int w);
        return (w != 0) ? bus.rsp1_c : bus.rsp0_c;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(7))
            0:       return '0;
            1:       return '1;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic set_req(input int w, input logic v, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic clr);
        if (w == 0) begin
            bus.req0_valid = v;
            bus.req0_a     = a;
            bus.req0_b     = b;
`ifdef MUL_SCHED_MAC_EN
            bus.req0_clr   = clr;
`endif
        end else begin
            bus.req1_valid = v;
            bus.req1_a     = a;
            bus.req1_b     = b;
`ifdef MUL_SCHED_MAC_EN
            bus.req1_clr   = clr;
`endif
        end
        if (clr === 1'bx) $display("note: clr undriven");
    endtask

    task automatic set_rsp_ready(input int w, input logic v);
        if (w == 0) bus.rsp0_ready = v;
        else        bus.rsp1_ready = v;
    endtask

    task automatic do_reset();
        set_req(0, 1'b0, '0, '0, 1'b0);
        set_req(1, 1'b0, '0, '0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One isolated transaction; returns the product and accept-to-valid latency.
    task automatic run_op(input int w, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic clr,
                          output prod_t c, output int lat);
        int n;
        set_rsp_ready(w, 1'b1);
        set_req(w, 1'b1, a, b, clr);
        #1;
        n = 0;
        while (!rdy(w) && n < 20) begin
            tick();
            #1;
            n++;
        end
        check("accept", 64'(rdy(w)), 64'd1);
        tick();
        #1;
        check("ready_pulse", 64'(rdy(w)), 64'd0);
        check("busy", 64'(bus.busy), 64'd1);
        set_req(w, 1'b0, a, b, clr);
        lat = 1;
        while (!rv(w) && lat < 40) begin
            tick();
            #1;
            lat++;
        end
        c = rc(w);
        tick();
    endtask

    vec_t  vecs[6];
    prod_t c;
    int    lat;
    int    n;
    int    k;
    int    order[4];
    prod_t c0;
    prod_t c1;
    logic  flag;

    // Random-phase reference state
    logic       vld[2];
    logic [W-1:0] ra[2];
    logic [W-1:0] rb[2];
    logic       rcl[2];
    logic       rr[2];
    prod_t      accm[2];
    prod_t      q_exp;
    prod_t      hold_c;
    int         owner;
    bit         outst;
    bit         seen;
    int         acc_cyc;
    int         prev_g;
    int         exp_g;
    int         done;
    int         limit;

    initial begin
        vecs[0] = '{0, 16'd3,      16'd5,      32'd15};
        vecs[1] = '{1, 16'hFFFF,   16'hFFFF,   32'hFFFE0001};
        vecs[2] = '{0, 16'h0000,   16'hABCD,   32'h0};
        vecs[3] = '{1, 16'hFFFF,   16'h0001,   32'h0000FFFF};
        vecs[4] = '{0, 16'h8000,   16'h0002,   32'h00010000};
        vecs[5] = '{1, 16'h1234,   16'h0010,   32'h00012340};

        set_req(0, 1'b0, '0, '0, 1'b0);
        set_req(1, 1'b0, '0, '0, 1'b0);
        set_rsp_ready(0, 1'b1);
        set_rsp_ready(1, 1'b1);
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_rsp0_valid", 64'(bus.rsp0_valid), 64'd0);
        check("rst_mul_a", 64'(bus.mul_a), 64'd0);
        tick();
        tick();
        rst = 1'b0;

        // Reset in the middle of WAIT aborts the op.
        set_req(0, 1'b1, 16'd3, 16'd5, 1'b1);
        #1;
        n = 0;
        while (!bus.req0_ready && n < 20) begin
            tick();
            #1;
            n++;
        end
        check("t1_accept", 64'(bus.req0_ready), 64'd1);
        tick();
        #1;
        check("t1_wait_busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        #1;
        check("t1_busy", 64'(bus.busy), 64'd0);
        check("t1_rsp0_valid", 64'(bus.rsp0_valid), 64'd0);
        check("t1_rsp1_valid", 64'(bus.rsp1_valid), 64'd0);
        check("t1_req0_ready", 64'(bus.req0_ready), 64'd0);
        check("t1_mul_a", 64'(bus.mul_a), 64'd0);
        check("t1_mul_b", 64'(bus.mul_b), 64'd0);
        check("t1_rsp_c", 64'(bus.rsp0_c), 64'd0);
        tick();
        tick();
        set_req(0, 1'b0, '0, '0, 1'b0);
        rst = 1'b0;
        flag = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (bus.rsp0_valid || bus.rsp1_valid) flag = 1'b1;
            tick();
        end
        check("t1_no_rsp_after_rst", 64'(flag), 64'd0);

        // Directed single-op vectors
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].w, vecs[i].a, vecs[i].b, 1'b1, c, lat);
            check("vec_c", 64'(c), 64'(vecs[i].c));
            check("vec_latency", 64'(lat), 64'(LAT));
        end

        // Tie: both valid continuously must alternate starting with 0.
        do_reset();
        set_rsp_ready(0, 1'b1);
        set_rsp_ready(1, 1'b1);
        set_req(0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
        set_req(1, 1'b1, 16'd2, 16'd7, 1'b1);
        for (int i = 0; i < 4; i++) order[i] = -1;
        c0 = '0;
        c1 = '0;
        k = 0;
        n = 0;
        while (k < 4 && n < 100) begin
            #1;
            if (bus.req0_ready) begin
                order[k] = 0;
                k++;
            end else if (bus.req1_ready) begin
                order[k] = 1;
                k++;
            end
            if (bus.rsp0_valid) c0 = bus.rsp0_c;
            if (bus.rsp1_valid) c1 = bus.rsp1_c;
            tick();
            n++;
        end
        set_req(0, 1'b0, '0, '0, 1'b1);
        set_req(1, 1'b0, '0, '0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            #1;
            if (bus.rsp0_valid) c0 = bus.rsp0_c;
            if (bus.rsp1_valid) c1 = bus.rsp1_c;
            tick();
        end
        check("tie_count", 64'(k), 64'd4);
        for (int i = 0; i < 4; i++)
            check("tie_order", 64'(order[i]), 64'(i % 2));
        check("tie_rsp0_c", 64'(c0), 64'h00000000FFFE0001);
        check("tie_rsp1_c", 64'(c1), 64'd14);

        // Backpressure on requester 1 while requester 0 waits.
        set_rsp_ready(1, 1'b0);
        set_req(1, 1'b1, 16'h1234, 16'h5678, 1'b1);
        #1;
        n = 0;
        while (!bus.req1_ready && n < 20) begin
            tick();
            #1;
            n++;
        end
        check("bp_accept", 64'(bus.req1_ready), 64'd1);
        tick();
        set_req(1, 1'b0, '0, '0, 1'b1);
        set_req(0, 1'b1, 16'd9, 16'd9, 1'b1);
        #1;
        n = 0;
        while (!bus.rsp1_valid && n < 20) begin
            tick();
            #1;
            n++;
        end
        check("bp_rsp_seen", 64'(bus.rsp1_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 64'(bus.rsp1_valid), 64'd1);
            check("bp_c", 64'(bus.rsp1_c), 64'h06260060);
            check("bp_req0_ready", 64'(bus.req0_ready), 64'd0);
            check("bp_rsp0_valid", 64'(bus.rsp0_valid), 64'd0);
            tick();
            #1;
        end
        set_rsp_ready(1, 1'b1);
        n = 0;
        while (!bus.req0_ready && n < 20) begin
            tick();
            #1;
            n++;
        end
        check("bp_req0_accept", 64'(bus.req0_ready), 64'd1);
        tick();
        set_req(0, 1'b0, '0, '0, 1'b1);
        #1;
        n = 0;
        while (!bus.rsp0_valid && n < 20) begin
            tick();
            #1;
            n++;
        end
        check("bp_req0_c", 64'(bus.rsp0_c), 64'd81);
        tick();
        tick();

`ifdef MUL_SCHED_MAC_EN
        do_reset();
        run_op(0, 16'd2, 16'd3, 1'b0, c, lat);
        check("mac_1", 64'(c), 64'd6);
        run_op(0, 16'd4, 16'd5, 1'b0, c, lat);
        check("mac_2", 64'(c), 64'd26);
        run_op(0, 16'd1, 16'd1, 1'b1, c, lat);
        check("mac_clr", 64'(c), 64'd1);
`endif

        // Randomized traffic with response stalls
        do_reset();
        for (int w = 0; w < 2; w++) begin
            vld[w]  = 1'b0;
            ra[w]   = '0;
            rb[w]   = '0;
            rcl[w]  = 1'b0;
            rr[w]   = 1'b1;
            accm[w] = '0;
        end
        outst  = 1'b0;
        seen   = 1'b0;
        owner  = 0;
        prev_g = 1;
        q_exp  = '0;
        hold_c = '0;
        acc_cyc = 0;
        done   = 0;
        limit  = cyc_n + 40000;
        while (done < 1000 && cyc_n < limit) begin
            for (int w = 0; w < 2; w++) begin
                if (!vld[w]) begin
                    if ($urandom_range(3) == 0) begin
                        vld[w] = 1'b1;
                        ra[w]  = rnd_op();
                        rb[w]  = rnd_op();
                        rcl[w] = ($urandom_range(3) == 0);
                    end
                end else if ($urandom_range(15) == 0) begin
                    vld[w] = 1'b0;
                end
                set_req(w, vld[w], ra[w], rb[w], rcl[w]);
                rr[w] = ($urandom_range(2) != 0);
                set_rsp_ready(w, rr[w]);
            end
            #1;
            if (bus.req0_ready && bus.req1_ready)
                check("dual_ready", 64'd1, 64'd0);
            exp_g = (vld[0] && vld[1]) ? 1 - prev_g : (vld[1] ? 1 : 0);
            for (int w = 0; w < 2; w++) begin
                if (rdy(w)) begin
                    check("ready_while_busy", 64'(outst), 64'd0);
                    check("grant", 64'(w), 64'(exp_g));
                    q_exp = prod_t'(ra[w]) * prod_t'(rb[w]);
`ifdef MUL_SCHED_MAC_EN
                    if (!rcl[w]) q_exp = q_exp + accm[w];
`endif
                    owner   = w;
                    outst   = 1'b1;
                    seen    = 1'b0;
                    acc_cyc = cyc_n;
                    prev_g  = w;
                    vld[w]  = 1'b0;
                end
            end
            for (int w = 0; w < 2; w++) begin
                if (rv(w)) begin
                    check("rsp_owner", 64'(outst && owner == w), 64'd1);
                    if (!seen)
                        check("rand_latency", 64'(cyc_n - acc_cyc), 64'(LAT));
                    else
                        check("rsp_stable", 64'(rc(w)), 64'(hold_c));
                    check("rand_c", 64'(rc(w)), 64'(q_exp));
                    seen   = 1'b1;
                    hold_c = rc(w);
                    if (rr[w]) begin
                        outst   = 1'b0;
                        accm[w] = q_exp;
                        done++;
                    end
                end
            end
            tick();
        end
        check("random_done", 64'(done >= 1000), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
